// File: rtl/mips_pkg.sv
// Shared opcodes, constants and FSM state type for the MEM pipeline stage.
package mips_pkg;

    localparam logic [4:0] OP_LD    = 5'h0C;
    localparam logic [4:0] OP_ST    = 5'h0D;
    localparam logic [4:0] OP_NOP   = 5'h1F;
    localparam logic [7:0] ERR_DATA = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mem_state_t;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-RAM request/acknowledge port between the MEM stage (master) and the RAM (slave).
interface mem_stage_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic              MEM_REQ;
    logic              MEM_WE;
    logic [DATA_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MEM_ACK;
    logic [DATA_W-1:0] MEM_RDATA;

    modport master (
        output MEM_REQ,
        output MEM_WE,
        output MEM_ADDR,
        output MEM_WDATA,
        input  MEM_ACK,
        input  MEM_RDATA
    );

    modport slave (
        input  MEM_REQ,
        input  MEM_WE,
        input  MEM_ADDR,
        input  MEM_WDATA,
        output MEM_ACK,
        output MEM_RDATA
    );

endinterface

// File: rtl/mem_stage_timeout_ctr.sv
// Busy-cycle counter; hit flags the enabled cycle in which the count reaches Limit.
module mem_timeout_ctr #(
    parameter int unsigned Limit = 15,
    parameter int unsigned Width = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // cnt_q holds the number of completed busy cycles, so this cycle is number cnt_q + 1.
    assign hit = en && (cnt_q == Width'(Limit - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues LD/ST on the data-RAM port, stalls upstream until ack or timeout.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        EXMEM_OPCODE,
    input  logic [DATA_W-1:0] EXMEM_ALU_OUT,
    input  logic [DATA_W-1:0] EXMEM_R2_DATA,
    mem_stage_if.master       ram,
    output logic [4:0]        MEM_OPCODE,
    output logic [DATA_W-1:0] R_DATA,
    output logic              MEM_STALL,
    output logic              MEM_ERR
);

    mem_state_t        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              ctr_clr, ctr_en, ctr_hit;
    logic              is_mem;

    assign is_mem = is_mem_op(EXMEM_OPCODE);

    mem_timeout_ctr #(
        .Limit (TIMEOUT),
        .Width (8)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst_n (rst),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .hit   (ctr_hit)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        ctr_clr = 1'b0;
        ctr_en  = 1'b0;
        case (state_q)
            StIdle: begin
                if (is_mem) begin
                    state_d = StBusy;
                    req_d   = 1'b1;
                    we_d    = (EXMEM_OPCODE == OP_ST);
                    addr_d  = EXMEM_ALU_OUT;
                    wdata_d = EXMEM_R2_DATA;
                    ctr_clr = 1'b1;
                end
            end
            StBusy: begin
                ctr_en = 1'b1;
                // Ack takes priority over a simultaneous timeout.
                if (ram.MEM_ACK) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = ram.MEM_RDATA;
                    end
                end else if (ctr_hit) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = DATA_W'(ERR_DATA);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    // Reset gates the combinational pipeline outputs so upstream sees NOP and no stall.
    always_comb begin
        MEM_STALL  = 1'b0;
        MEM_OPCODE = OP_NOP;
        if (rst) begin
            case (state_q)
                StIdle: begin
                    MEM_STALL  = is_mem;
                    MEM_OPCODE = is_mem ? OP_NOP : EXMEM_OPCODE;
                end
                StBusy: begin
                    MEM_STALL = 1'b1;
                end
                StDone: begin
                    MEM_OPCODE = EXMEM_OPCODE;
                end
                default: begin
                    MEM_OPCODE = OP_NOP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign ram.MEM_REQ   = req_q;
    assign ram.MEM_WE    = we_q;
    assign ram.MEM_ADDR  = addr_q;
    assign ram.MEM_WDATA = wdata_q;
    assign R_DATA        = rdata_q;
    assign MEM_ERR       = err_q;

endmodule
